// File: rtl/sockit_spi_pkg.sv
// Shared types and constants for the SPI arbiter: FSM encoding and mux select codes.
package sockit_spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GXIP  = 2'd1,
    GREG  = 2'd2,
    DRAIN = 2'd3
  } arb_state_t;

  localparam logic SEL_XIP = 1'b0;
  localparam logic SEL_REG = 1'b1;

endpackage

// File: rtl/sockit_spi_arb.sv
// Arbiter between XIP and REG/DMA requesters sharing the serializer command/data path.
// A grant covers a whole SPI transaction including the read data still outstanding.
module sockit_spi_arb
  import sockit_spi_pkg::*;
#(
  parameter logic        RRB = 1'b1,
  parameter int unsigned RCW = 8,
  parameter logic [15:0] HLD = 16'd0
)(
  input  logic           clk,
  input  logic           rst,
  input  logic           req_xip,
  input  logic           req_reg,
  input  logic           cmd_vld,
  input  logic           cmd_rdy,
  input  logic           cmd_lst,
  input  logic [RCW-1:0] cmd_rdn,
  input  logic           sdr_vld,
  input  logic           sdr_rdy,
  output logic           sel,
  output logic           gnt,
  output logic           bsy,
  output logic           err
);

  arb_state_t     state, state_nxt;
  logic [RCW-1:0] cnt, cnt_nxt;
  logic [15:0]    tmr, tmr_nxt;
  logic           win, win_nxt;
  logic           sel_nxt;
  logic           cmd_trn, sdr_trn;
  logic           cnt_err, tmo;
  logic [RCW:0]   sum, dif;

  assign cmd_trn = cmd_vld & cmd_rdy & gnt;
  assign sdr_trn = sdr_vld & sdr_rdy;
  assign bsy     = (state != IDLE);

  // Add and decrement are evaluated together so a read completing in the same
  // cycle as a new command never trips a spurious underflow.
  always_comb begin
    cnt_err = 1'b0;
    sum     = {1'b0, cnt} + (cmd_trn ? {1'b0, cmd_rdn} : '0);
    dif     = sum;
    if (sdr_trn) begin
      if (sum == '0) cnt_err = 1'b1;
      else           dif     = sum - 1'b1;
    end
    if (dif > {1'b0, {RCW{1'b1}}}) begin
      cnt_nxt = '1;
      cnt_err = 1'b1;
    end else begin
      cnt_nxt = dif[RCW-1:0];
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    win_nxt   = win;
    tmr_nxt   = '0;
    tmo       = 1'b0;
    case (state)
      IDLE: begin
        if (req_xip && (!req_reg || !RRB || win == SEL_REG)) begin
          state_nxt = GXIP;
          sel_nxt   = SEL_XIP;
          win_nxt   = SEL_XIP;
        end else if (req_reg) begin
          state_nxt = GREG;
          sel_nxt   = SEL_REG;
          win_nxt   = SEL_REG;
        end
      end
      GXIP, GREG: begin
        if (cmd_trn) begin
          if (cmd_lst) state_nxt = (cnt_nxt != '0) ? DRAIN : IDLE;
        end else if (HLD != 16'd0) begin
          tmr_nxt = tmr + 16'd1;
          if (tmr_nxt >= HLD) begin
            tmo       = 1'b1;
            state_nxt = (cnt_nxt != '0) ? DRAIN : IDLE;
          end
        end
      end
      DRAIN: begin
        if (cnt_nxt == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel   <= SEL_XIP;
      gnt   <= 1'b0;
      err   <= 1'b0;
      cnt   <= '0;
      tmr   <= '0;
      win   <= SEL_REG;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      gnt   <= (state_nxt == GXIP) || (state_nxt == GREG);
      err   <= err | cnt_err | tmo;
      cnt   <= cnt_nxt;
      tmr   <= tmr_nxt;
      win   <= win_nxt;
    end
  end

endmodule

// File: tb/tb_sockit_spi_arb.sv
// Scenario bench for sockit_spi_arb: two instances (round-robin/unlimited hold and
// fixed-priority/2-bit counter/hold limit 5) with a grant-order scoreboard.
module tb_sockit_spi_arb;
  import sockit_spi_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_xip, req_reg, cmd_vld, cmd_rdy, cmd_lst, sdr_vld, sdr_rdy;
  logic [1:0] sel, gnt, bsy, err;
  logic [7:0] rdn_a;
  logic [1:0] rdn_b;

  int   n_chk = 0;
  int   n_fail = 0;
  logic exp_q[$];
  logic last_w[2];

  always #5 clk = ~clk;

  sockit_spi_arb #(.RRB(1'b1), .RCW(8), .HLD(16'd0)) dut_a (
    .clk(clk), .rst(rst), .req_xip(req_xip[0]), .req_reg(req_reg[0]),
    .cmd_vld(cmd_vld[0]), .cmd_rdy(cmd_rdy[0]), .cmd_lst(cmd_lst[0]), .cmd_rdn(rdn_a),
    .sdr_vld(sdr_vld[0]), .sdr_rdy(sdr_rdy[0]),
    .sel(sel[0]), .gnt(gnt[0]), .bsy(bsy[0]), .err(err[0])
  );

  sockit_spi_arb #(.RRB(1'b0), .RCW(2), .HLD(16'd5)) dut_b (
    .clk(clk), .rst(rst), .req_xip(req_xip[1]), .req_reg(req_reg[1]),
    .cmd_vld(cmd_vld[1]), .cmd_rdy(cmd_rdy[1]), .cmd_lst(cmd_lst[1]), .cmd_rdn(rdn_b),
    .sdr_vld(sdr_vld[1]), .sdr_rdy(sdr_rdy[1]),
    .sel(sel[1]), .gnt(gnt[1]), .bsy(bsy[1]), .err(err[1])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rdn(input int d, input int v);
    if (d == 0) rdn_a = 8'(v);
    else        rdn_b = 2'(v);
  endtask

  // Expected winner for a request pattern; dut_a is round-robin, dut_b fixed priority.
  task automatic push_win(input int d, input logic x, input logic r);
    logic w;
    if (x && (!r || d == 1 || last_w[d] == SEL_REG)) w = SEL_XIP;
    else                                              w = SEL_REG;
    exp_q.push_back(w);
    last_w[d] = w;
  endtask

  task automatic grant_check(input int d, input string tag);
    logic want;
    tick();
    n_chk++;
    if (gnt[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_latency: gnt=%b want 1", tag, gnt[d]);
      for (int i = 0; i < 8 && gnt[d] !== 1'b1; i++) tick();
    end
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s_sel: grant seen but no expected winner queued", tag);
    end else begin
      want = exp_q.pop_front();
      if (sel[d] !== want || gnt[d] !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_sel: sel=%b gnt=%b want sel=%b gnt=1", tag, sel[d], gnt[d], want);
      end
    end
  endtask

  task automatic cmd(input int d, input logic lst, input int rdn, input logic with_sdr);
    cmd_vld[d] = 1'b1;
    cmd_rdy[d] = 1'b1;
    cmd_lst[d] = lst;
    set_rdn(d, rdn);
    sdr_vld[d] = with_sdr;
    sdr_rdy[d] = with_sdr;
    tick();
    cmd_vld[d] = 1'b0;
    cmd_rdy[d] = 1'b0;
    cmd_lst[d] = 1'b0;
    set_rdn(d, 0);
    sdr_vld[d] = 1'b0;
    sdr_rdy[d] = 1'b0;
  endtask

  task automatic drain(input int d, input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      sdr_vld[d] = 1'b1;
      sdr_rdy[d] = 1'b1;
      tick();
      sdr_vld[d] = 1'b0;
      sdr_rdy[d] = 1'b0;
      n_chk++;
      if (bsy[d] !== (k < n - 1)) begin
        n_fail++;
        $display("FAIL %s_drain%0d: bsy=%b want %b", tag, k, bsy[d], (k < n - 1));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_xip = '0; req_reg = '0; cmd_vld = '0; cmd_rdy = '0; cmd_lst = '0;
    sdr_vld = '0; sdr_rdy = '0; rdn_a = '0; rdn_b = '0;
    tick();
    tick();
    rst = 1'b0;
    last_w[0] = SEL_REG;
    last_w[1] = SEL_REG;
    for (int d = 0; d < 2; d++) begin
      n_chk += 4;
      if (gnt[d] !== 1'b0) begin n_fail++; $display("FAIL reset_gnt%0d: got %b want 0", d, gnt[d]); end
      if (sel[d] !== 1'b0) begin n_fail++; $display("FAIL reset_sel%0d: got %b want 0", d, sel[d]); end
      if (bsy[d] !== 1'b0) begin n_fail++; $display("FAIL reset_bsy%0d: got %b want 0", d, bsy[d]); end
      if (err[d] !== 1'b0) begin n_fail++; $display("FAIL reset_err%0d: got %b want 0", d, err[d]); end
    end
  endtask

  task automatic test_single_read();
    req_xip[0] = 1'b1;
    push_win(0, 1'b1, 1'b0);
    grant_check(0, "single");
    req_xip[0] = 1'b0;
    cmd(0, 1'b1, 4, 1'b0);
    n_chk++;
    if (gnt[0] !== 1'b0 || bsy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL single_drain_entry: gnt=%b bsy=%b want gnt=0 bsy=1", gnt[0], bsy[0]);
    end
    sdr_vld[0] = 1'b1;
    tick();
    sdr_vld[0] = 1'b0;
    n_chk++;
    if (bsy[0] !== 1'b1) begin n_fail++; $display("FAIL single_stall: bsy=%b want 1", bsy[0]); end
    drain(0, 4, "single");
    n_chk++;
    if (err[0] !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b want 0", err[0]); end
  endtask

  task automatic test_round_robin();
    logic prev;
    req_xip[0] = 1'b1;
    req_reg[0] = 1'b1;
    for (int t = 0; t < 4; t++) push_win(0, 1'b1, 1'b1);
    for (int t = 0; t < 4; t++) begin
      grant_check(0, "rr");
      prev = sel[0];
      cmd(0, 1'b0, 0, 1'b0);
      n_chk++;
      if (gnt[0] !== 1'b1 || sel[0] !== prev) begin
        n_fail++;
        $display("FAIL rr_hold%0d: gnt=%b sel=%b want gnt=1 sel=%b", t, gnt[0], sel[0], prev);
      end
      cmd(0, 1'b1, 0, 1'b0);
      if (t == 3) begin
        req_xip[0] = 1'b0;
        req_reg[0] = 1'b0;
      end
      n_chk++;
      if (gnt[0] !== 1'b0 || bsy[0] !== 1'b0 || sel[0] !== prev) begin
        n_fail++;
        $display("FAIL rr_release%0d: gnt=%b bsy=%b sel=%b want 0 0 %b", t, gnt[0], bsy[0], sel[0], prev);
      end
    end
  endtask

  task automatic test_fixed_priority();
    req_xip[1] = 1'b1;
    req_reg[1] = 1'b1;
    for (int t = 0; t < 3; t++) push_win(1, 1'b1, 1'b1);
    push_win(1, 1'b0, 1'b1);
    for (int t = 0; t < 4; t++) begin
      grant_check(1, "fp");
      if (t == 2) req_xip[1] = 1'b0;
      if (t == 3) req_reg[1] = 1'b0;
      cmd(1, 1'b1, 0, 1'b0);
      n_chk++;
      if (gnt[1] !== 1'b0 || bsy[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL fp_release%0d: gnt=%b bsy=%b want 0 0", t, gnt[1], bsy[1]);
      end
    end
  endtask

  task automatic test_add_dec();
    req_xip[0] = 1'b1;
    push_win(0, 1'b1, 1'b0);
    grant_check(0, "adddec");
    req_xip[0] = 1'b0;
    cmd(0, 1'b0, 3, 1'b0);
    n_chk++;
    if (gnt[0] !== 1'b1) begin n_fail++; $display("FAIL adddec_hold: gnt=%b want 1", gnt[0]); end
    cmd(0, 1'b1, 2, 1'b1);
    n_chk++;
    if (gnt[0] !== 1'b0 || bsy[0] !== 1'b1 || err[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL adddec_drain: gnt=%b bsy=%b err=%b want 0 1 0", gnt[0], bsy[0], err[0]);
    end
    drain(0, 4, "adddec");
    n_chk++;
    if (err[0] !== 1'b0) begin n_fail++; $display("FAIL adddec_err: got %b want 0", err[0]); end
  endtask

  task automatic test_underflow();
    sdr_vld[0] = 1'b1;
    sdr_rdy[0] = 1'b1;
    tick();
    sdr_vld[0] = 1'b0;
    sdr_rdy[0] = 1'b0;
    n_chk++;
    if (err[0] !== 1'b1 || bsy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL underflow_err: err=%b bsy=%b want 1 0", err[0], bsy[0]);
    end
    req_reg[0] = 1'b1;
    push_win(0, 1'b0, 1'b1);
    grant_check(0, "underflow");
    req_reg[0] = 1'b0;
    cmd(0, 1'b1, 1, 1'b0);
    n_chk++;
    if (bsy[0] !== 1'b1) begin n_fail++; $display("FAIL underflow_drain: bsy=%b want 1", bsy[0]); end
    drain(0, 1, "underflow");
  endtask

  task automatic test_timeout();
    req_xip[1] = 1'b1;
    push_win(1, 1'b1, 1'b0);
    grant_check(1, "timeout");
    req_xip[1] = 1'b0;
    cmd_vld[1] = 1'b1;
    n_chk++;
    if (err[1] !== 1'b0) begin n_fail++; $display("FAIL timeout_pre_err: got %b want 0", err[1]); end
    for (int k = 1; k < 5; k++) begin
      tick();
      n_chk++;
      if (gnt[1] !== 1'b1) begin n_fail++; $display("FAIL timeout_hold%0d: gnt=%b want 1", k, gnt[1]); end
    end
    tick();
    cmd_vld[1] = 1'b0;
    n_chk++;
    if (gnt[1] !== 1'b0 || bsy[1] !== 1'b0 || err[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_release: gnt=%b bsy=%b err=%b want 0 0 1", gnt[1], bsy[1], err[1]);
    end
  endtask

  task automatic test_reset_mid();
    req_reg[1] = 1'b1;
    push_win(1, 1'b0, 1'b1);
    grant_check(1, "rstmid");
    req_reg[1] = 1'b0;
    cmd(1, 1'b1, 2, 1'b0);
    n_chk++;
    if (bsy[1] !== 1'b1 || sel[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_drain: bsy=%b sel=%b want 1 1", bsy[1], sel[1]);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_w[0] = SEL_REG;
    last_w[1] = SEL_REG;
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (bsy[d] !== 1'b0 || sel[d] !== 1'b0 || gnt[d] !== 1'b0 || err[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_state%0d: bsy=%b sel=%b gnt=%b err=%b want all 0", d, bsy[d], sel[d], gnt[d], err[d]);
      end
    end
    req_xip[1] = 1'b1;
    push_win(1, 1'b1, 1'b0);
    grant_check(1, "rstmid_after");
    req_xip[1] = 1'b0;
    cmd(1, 1'b1, 1, 1'b0);
    drain(1, 1, "rstmid_after");
  endtask

  task automatic test_saturate();
    req_reg[1] = 1'b1;
    push_win(1, 1'b0, 1'b1);
    grant_check(1, "sat");
    req_reg[1] = 1'b0;
    cmd(1, 1'b0, 3, 1'b0);
    n_chk++;
    if (err[1] !== 1'b0 || gnt[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_first: err=%b gnt=%b want 0 1", err[1], gnt[1]);
    end
    cmd(1, 1'b1, 2, 1'b0);
    n_chk++;
    if (err[1] !== 1'b1 || bsy[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_overflow: err=%b bsy=%b want 1 1", err[1], bsy[1]);
    end
    drain(1, 3, "sat");
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_fixed_priority();
    test_add_dec();
    test_underflow();
    test_timeout();
    test_reset_mid();
    test_saturate();
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: %0d entries want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
